// File: rtl/imem_loader_if.sv
// imem_loader_if: load stream, start/len control and instruction-memory write bundle for imem_loader_ctrl.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              imem_sel;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, len, s_valid, s_data,
    input  s_ready, imem_we, imem_waddr, imem_wdata, imem_sel, cpu_run, busy, done, err
  );
  modport slave (
    input  start, len, s_valid, s_data,
    output s_ready, imem_we, imem_waddr, imem_wdata, imem_sel, cpu_run, busy, done, err
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: streams words into instruction memory, then releases the core from address 0.
// Define IMEM_CHECKSUM_EN to require a trailer word matching the running sum of loaded words.
module imem_loader_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, FAIL} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FAIL} state_t;
`endif
  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [ADDR_W:0] DEPTH = ONE << ADDR_W;
  state_t state_q, state_d;
  logic [ADDR_W:0] len_q, len_d, acc_q, acc_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d, rdy_q, rdy_d, done_q, done_d, err_q, err_d;
  logic hs, last, len_ok, run;
`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`else
  logic last_q, last_d;
`endif
  assign hs = bus.s_valid && rdy_q;
  assign last = acc_q + ONE == len_q;
  assign len_ok = bus.len != '0 && bus.len <= DEPTH;
  assign run = state_q == RUN;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    acc_d = acc_q;
    cnt_d = we_q ? cnt_q + ADDR_W'(1) : cnt_q;
    we_d = hs && state_q == LOAD;
    wdata_d = we_d ? bus.s_data : wdata_q;
    done_d = done_q;
    err_d = err_q;
`ifdef IMEM_CHECKSUM_EN
    sum_d = we_d ? sum_q + bus.s_data : sum_q;
`else
    last_d = we_d && last;
`endif
    case (state_q)
      LOAD: begin
        acc_d = hs ? acc_q + ONE : acc_q;
`ifdef IMEM_CHECKSUM_EN
        state_d = hs && last ? CHECK : LOAD;
`else
        // release only after the final write pulse has landed
        state_d = last_q ? RUN : LOAD;
        done_d = last_q;
`endif
      end
`ifdef IMEM_CHECKSUM_EN
      CHECK: if (hs) begin
        state_d = bus.s_data == sum_q ? RUN : FAIL;
        done_d = bus.s_data == sum_q;
        err_d = bus.s_data != sum_q;
      end
`endif
      default: if (bus.start) begin
        state_d = len_ok ? LOAD : FAIL;
        err_d = !len_ok;
        if (len_ok) begin
          len_d = bus.len;
          acc_d = '0;
          cnt_d = '0;
          done_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          sum_d = '0;
`endif
        end
      end
    endcase
`ifdef IMEM_CHECKSUM_EN
    rdy_d = state_d == LOAD || state_d == CHECK;
`else
    rdy_d = state_d == LOAD && !last_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rdy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_q <= '0;
`else
      last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      rdy_q <= rdy_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q <= sum_d;
`else
      last_q <= last_d;
`endif
    end
  end
  assign bus.s_ready = rdy_q;
  assign bus.imem_we = we_q;
  assign bus.imem_waddr = cnt_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_run = run;
  assign bus.imem_sel = !run;
`ifdef IMEM_CHECKSUM_EN
  assign bus.busy = state_q == LOAD || state_q == CHECK;
`else
  assign bus.busy = state_q == LOAD;
`endif
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: scoreboard bench; expected writes are queued at each handshake and popped by a write monitor.
module tb_imem_loader_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  imem_loader_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];
  int total = 0;
  int passed = 0;
  int exp_addr = 0;
  int writes = 0;
  logic [31:0] sum = '0;

  always @(negedge clk) if (bus.imem_we === 1'b1) begin
    wr_t e;
    writes++;
    total++;
    if (exp_q.size() == 0) $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.imem_waddr, bus.imem_wdata);
    else begin
      e = exp_q.pop_front();
      if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data)
        $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
      else passed++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [8:0] l);
    bus.start = 1'b1;
    bus.len = l;
    if (l != 0 && l <= 256) begin
      exp_addr = 0;
      sum = '0;
    end
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input bit wr);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data = w;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (bus.s_ready !== 1'b1) begin
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, n);
      bus.s_valid = 1'b0;
      return;
    end
    passed++;
    if (wr) begin
      exp_q.push_back({exp_addr[7:0], w});
      exp_addr++;
      sum += w;
    end
    cyc();
    bus.s_valid = 1'b0;
    if (wr) begin
      total++;
      if (bus.imem_we !== 1'b1) $display("FAIL write_latency: imem_we=%b one cycle after handshake, required 1", bus.imem_we);
      else passed++;
    end
  endtask

  task automatic finish_load();
`ifdef IMEM_CHECKSUM_EN
    send(sum, 1'b0);
`else
    cyc();
`endif
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.len = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    total++; if (bus.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b required 0", bus.s_ready); else passed++;
    total++; if (bus.imem_we !== 1'b0) $display("FAIL rst_imem_we: got %b required 0", bus.imem_we); else passed++;
    total++; if (bus.imem_waddr !== 8'd0) $display("FAIL rst_waddr: got %0d required 0", bus.imem_waddr); else passed++;
    total++; if (bus.imem_wdata !== 32'd0) $display("FAIL rst_wdata: got %h required 0", bus.imem_wdata); else passed++;
    total++; if (bus.imem_sel !== 1'b1) $display("FAIL rst_imem_sel: got %b required 1", bus.imem_sel); else passed++;
    total++; if (bus.cpu_run !== 1'b0) $display("FAIL rst_cpu_run: got %b required 0", bus.cpu_run); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b required 0", bus.done); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %b required 0", bus.err); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4] = '{32'h4C400000, 32'h4C800001, 32'h00000000, 32'hF8000000};
    go(9'd4);
    total++; if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) $display("FAIL b2b_start: busy=%b s_ready=%b, required 1 1", bus.busy, bus.s_ready); else passed++;
    for (int i = 0; i < 4; i++) send(w[i], 1'b1);
    total++; if (bus.cpu_run !== 1'b0) $display("FAIL b2b_early_run: cpu_run=%b during last write, required 0", bus.cpu_run); else passed++;
    finish_load();
    total++; if (bus.cpu_run !== 1'b1 || bus.done !== 1'b1) $display("FAIL b2b_release: cpu_run=%b done=%b, required 1 1", bus.cpu_run, bus.done); else passed++;
    total++; if (bus.imem_sel !== 1'b0 || bus.s_ready !== 1'b0 || bus.busy !== 1'b0) $display("FAIL b2b_run_outputs: sel=%b s_ready=%b busy=%b, required 0 0 0", bus.imem_sel, bus.s_ready, bus.busy); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL b2b_pending: %0d writes missing, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_full_depth();
    int w0;
    go(9'd256);
    w0 = writes;
    for (int i = 0; i < 256; i++) begin
      send(32'(i) * 32'h9E3779B9 ^ 32'hA5A50000, 1'b1);
      if (i != 255) cyc();
    end
    finish_load();
    total++; if (bus.cpu_run !== 1'b1 || bus.done !== 1'b1) $display("FAIL full_release: cpu_run=%b done=%b, required 1 1", bus.cpu_run, bus.done); else passed++;
    cyc(3);
    total++; if (writes - w0 != 256) $display("FAIL full_count: got %0d writes required 256", writes - w0); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL full_pending: %0d writes missing, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_bad_len();
    logic [8:0] bad [2] = '{9'd0, 9'd257};
    for (int k = 0; k < 2; k++) begin
      bit seen = 1'b0;
      go(bad[k]);
      total++; if (bus.err !== 1'b1 || bus.cpu_run !== 1'b0 || bus.busy !== 1'b0) $display("FAIL bad_len_%0d: err=%b cpu_run=%b busy=%b, required 1 0 0", bad[k], bus.err, bus.cpu_run, bus.busy); else passed++;
      bus.s_valid = 1'b1;
      bus.s_data = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
        if (bus.s_ready !== 1'b0) seen = 1'b1;
        cyc();
      end
      bus.s_valid = 1'b0;
      total++; if (seen) $display("FAIL bad_len_ready_%0d: s_ready asserted, required never", bad[k]); else passed++;
    end
  endtask

  task automatic test_reset_midload();
    go(9'd4);
    send(32'h00000011, 1'b1);
    send(32'h00000022, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.cpu_run !== 1'b0 || bus.s_ready !== 1'b0 || bus.imem_we !== 1'b0) $display("FAIL midrst_idle: busy=%b cpu_run=%b s_ready=%b we=%b, required 0 0 0 0", bus.busy, bus.cpu_run, bus.s_ready, bus.imem_we); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL midrst_pending: %0d writes missing, required 0", exp_q.size()); else passed++;
    go(9'd4);
    for (int i = 0; i < 4; i++) send(32'h00000100 + 32'(i), 1'b1);
    finish_load();
    total++; if (bus.cpu_run !== 1'b1 || bus.done !== 1'b1) $display("FAIL midrst_reload: cpu_run=%b done=%b, required 1 1", bus.cpu_run, bus.done); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL midrst_reload_pending: %0d writes missing, required 0", exp_q.size()); else passed++;
  endtask

`ifdef IMEM_CHECKSUM_EN
  task automatic test_checksum();
    go(9'd2);
    send(32'd1, 1'b1);
    send(32'd2, 1'b1);
    send(32'd4, 1'b0);
    total++; if (bus.err !== 1'b1 || bus.cpu_run !== 1'b0 || bus.done !== 1'b0) $display("FAIL chk_bad: err=%b cpu_run=%b done=%b, required 1 0 0", bus.err, bus.cpu_run, bus.done); else passed++;
    go(9'd2);
    send(32'd1, 1'b1);
    send(32'd2, 1'b1);
    send(32'd3, 1'b0);
    total++; if (bus.err !== 1'b0 || bus.cpu_run !== 1'b1 || bus.done !== 1'b1) $display("FAIL chk_good: err=%b cpu_run=%b done=%b, required 0 1 1", bus.err, bus.cpu_run, bus.done); else passed++;
    cyc(2);
    total++; if (exp_q.size() != 0) $display("FAIL chk_pending: %0d writes missing, required 0", exp_q.size()); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_full_depth();
    test_bad_len();
    test_reset_midload();
`ifdef IMEM_CHECKSUM_EN
    test_checksum();
`endif
    cyc(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
